// File: rtl/rom_wr_pkg.sv
// rom_wr_pkg: types and constants shared by the ioctl ROM writer slice.
//   ROM_AW     : SDRAM word-address width carried in rom_word_t
//   BE_*       : byte-enable codes, bit 0 = sdr_data[7:0], bit 1 = sdr_data[15:8]
//   rom_word_t : one packed SDRAM write (address, data, byte enables)
//   wr_state_t : write-port FSM states
//   place_byte : puts a byte into the low or high lane of a 16-bit word
package rom_wr_pkg;

  localparam int ROM_AW = 24;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_FULL = 2'b11;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } rom_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wr_state_t;

  function automatic logic [15:0] place_byte(input logic [7:0] b, input logic hi);
    return hi ? {b, 8'h00} : {8'h00, b};
  endfunction

endpackage

// File: rtl/ioctl_rom_writer_if.sv
// ioctl_rom_writer_if: SDRAM write port with toggle req/ack handshake.
//   sdr_req  : toggles once per write request (master -> slave)
//   sdr_ack  : slave echoes sdr_req when the write has completed
//   sdr_addr : word address, sdr_data : write data, sdr_be : byte enables {hi,lo}
// Modports: master = ROM writer, slave = SDRAM controller.
interface ioctl_rom_writer_if #(
  parameter int AW = rom_wr_pkg::ROM_AW
);
  logic          sdr_req;
  logic          sdr_ack;
  logic [AW-1:0] sdr_addr;
  logic [15:0]   sdr_data;
  logic [1:0]    sdr_be;

  modport master (output sdr_req, sdr_addr, sdr_data, sdr_be, input sdr_ack);
  modport slave  (input sdr_req, sdr_addr, sdr_data, sdr_be, output sdr_ack);
endinterface

// File: rtl/rom_wr_fifo.sv
// rom_wr_fifo: show-ahead FIFO of rom_word_t, depth 2**FIFO_AW.
//   clk_sys, reset : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en/wr_data  : push; ignored when full unless a pop happens the same cycle
//   rd_en/rd_data  : pop; rd_data always shows the oldest entry
//   full/empty     : derived from pointers carrying one extra wrap bit
module rom_wr_fifo
  import rom_wr_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic      clk_sys,
  input  logic      reset,
  input  logic      wr_en,
  input  rom_word_t wr_data,
  input  logic      rd_en,
  output rom_word_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  rom_word_t          mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic               do_wr;
  logic               do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  // When full, a simultaneous pop frees the slot being written this cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ioctl_rom_writer.sv
// ioctl_rom_writer: packs data_io ROM download bytes into 16-bit SDRAM words,
// buffers them in rom_wr_fifo and writes them over a toggle req/ack port.
//   clk_sys, reset : clock, asynchronous active-high reset
//   rom_download   : high while a ROM download is in progress
//   ioctl_wr       : one-cycle byte strobe (ignored while rom_download=0)
//   ioctl_addr     : byte address, ioctl_dout : byte data
//   sdr            : SDRAM write port (master side)
//   busy           : pending byte, queued word or request outstanding
//   done           : one-cycle pulse once a finished download is fully written
//   overflow       : sticky, a word was dropped on a full FIFO; cleared on download start
//
// Write FSM
//   state | meaning
//   IDLE  | no request outstanding; pops the FIFO head and toggles sdr_req
//   WAIT  | request outstanding; outputs frozen until sdr_ack == sdr_req
module ioctl_rom_writer
  import rom_wr_pkg::*;
#(
  parameter int AW        = ROM_AW,   // must equal ROM_AW, the rom_word_t address width
  parameter int FIFO_AW   = 2,
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               rom_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  ioctl_rom_writer_if.master sdr,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  // Lane of the even byte of a word; the odd byte takes the other lane.
  localparam logic       EVEN_HI = BYTE_SWAP;
  localparam logic [1:0] BE_EVEN = BYTE_SWAP ? BE_HI : BE_LO;
  localparam logic [1:0] BE_ODD  = BYTE_SWAP ? BE_LO : BE_HI;

  logic          dl_q;
  logic          rise;
  logic          fall;
  logic          strobe;
  logic [AW-1:0] wr_word_addr;

  logic          pend_vld;
  logic [AW-1:0] pend_addr;
  logic [7:0]    pend_byte;
  logic          pend_eff;
  logic          same_word;

  logic          push_vld;
  rom_word_t     push_word;
  logic          hold_vld;
  rom_word_t     hold_word;

  rom_word_t     pend_word;
  rom_word_t     odd_word;
  rom_word_t     pair_word;

  rom_word_t     fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  wr_state_t     state;
  logic          end_pend;
  logic          done_cond;

  assign rise         = rom_download & ~dl_q;
  assign fall         = ~rom_download & dl_q;
  assign strobe       = ioctl_wr & rom_download;
  assign wr_word_addr = ioctl_addr[AW:1];
  // A download start discards any byte left over from the previous one.
  assign pend_eff     = pend_vld & ~rise;
  assign same_word    = (pend_addr == wr_word_addr);

  always_comb begin
    pend_word      = '0;
    pend_word.addr = pend_addr;
    pend_word.data = place_byte(pend_byte, EVEN_HI);
    pend_word.be   = BE_EVEN;

    odd_word       = '0;
    odd_word.addr  = wr_word_addr;
    odd_word.data  = place_byte(ioctl_dout, !EVEN_HI);
    odd_word.be    = BE_ODD;

    pair_word      = '0;
    pair_word.addr = pend_addr;
    pair_word.data = place_byte(pend_byte, EVEN_HI) | place_byte(ioctl_dout, !EVEN_HI);
    pair_word.be   = BE_FULL;
  end

  // Packer. Strobes are at least 4 cycles apart, so the held odd byte of a
  // split word is always pushed before the next strobe can arrive.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q      <= 1'b0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_byte <= '0;
      push_vld  <= 1'b0;
      push_word <= '0;
      hold_vld  <= 1'b0;
      hold_word <= '0;
    end else begin
      dl_q     <= rom_download;
      push_vld <= 1'b0;
      if (rise) pend_vld <= 1'b0;

      if (strobe) begin
        if (!ioctl_addr[0]) begin
          if (pend_eff) begin
            push_vld  <= 1'b1;
            push_word <= pend_word;
          end
          pend_vld  <= 1'b1;
          pend_addr <= wr_word_addr;
          pend_byte <= ioctl_dout;
        end else begin
          push_vld <= 1'b1;
          pend_vld <= 1'b0;
          if (pend_eff && same_word) begin
            push_word <= pair_word;
          end else if (pend_eff) begin
            push_word <= pend_word;
            hold_vld  <= 1'b1;
            hold_word <= odd_word;
          end else begin
            push_word <= odd_word;
          end
        end
      end else if (hold_vld) begin
        push_vld  <= 1'b1;
        push_word <= hold_word;
        hold_vld  <= 1'b0;
      end else if (fall && pend_vld) begin
        push_vld  <= 1'b1;
        push_word <= pend_word;
        pend_vld  <= 1'b0;
      end
    end
  end

  rom_wr_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .wr_en   (push_vld),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop = (state == IDLE) && !fifo_empty;

  // Nothing left anywhere in the pipe and the controller has caught up.
  assign done_cond = !pend_vld && !push_vld && !hold_vld && fifo_empty &&
                     (state == IDLE) && (sdr.sdr_ack == sdr.sdr_req);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sdr.sdr_req  <= 1'b0;
      sdr.sdr_addr <= '0;
      sdr.sdr_data <= '0;
      sdr.sdr_be   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      end_pend     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            sdr.sdr_addr <= fifo_dout.addr;
            sdr.sdr_data <= fifo_dout.data;
            sdr.sdr_be   <= fifo_dout.be;
            sdr.sdr_req  <= ~sdr.sdr_req;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (sdr.sdr_ack == sdr.sdr_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (rise) overflow <= 1'b0;
      if (push_vld && fifo_full && !pop) overflow <= 1'b1;

      if (rise)                       end_pend <= 1'b0;
      else if (fall)                  end_pend <= 1'b1;
      else if (end_pend && done_cond) end_pend <= 1'b0;

      done <= end_pend && done_cond && !rise && !fall;
      busy <= pend_vld || push_vld || hold_vld || !fifo_empty || (state == WAIT);
    end
  end

endmodule
